// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with a one-word holding buffer, feeding a
// downstream SIPO. Words stream back-to-back with no idle bit between them.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic             shift_en_i,
    output logic             serial_out_o,
    output logic             serial_valid_o,
    output logic             frame_start_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return {w[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, w[WIDTH-1:1]};
        end
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               load_ready_q;
    logic               serial_out_q;
    logic               serial_valid_q;
    logic               frame_start_q;
    logic               done_q, done_d;
    logic               accept_s;

    assign accept_s = load_valid_i & load_ready_q;

    // Next-state: transfer hold->shift, per-strobe shifting, and word capture.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_valid_q) begin
                    shift_d      = hold_q;
                    bit_cnt_d    = '0;
                    hold_valid_d = 1'b0;
                    state_d      = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_en_i) begin
                    if (bit_cnt_q == LAST_CNT) begin
                        done_d = 1'b1;
                        // Reload straight from hold so the next word follows without a gap.
                        if (hold_valid_q) begin
                            shift_d      = hold_q;
                            bit_cnt_d    = '0;
                            hold_valid_d = 1'b0;
                            state_d      = ST_SHIFT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        shift_d   = advance(shift_q);
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // load_ready is only high while hold is empty, so capture never races a transfer.
        if (accept_s) begin
            hold_d       = data_in_i;
            hold_valid_d = 1'b1;
        end else begin
            hold_d = hold_d;
        end
    end

    // State and output registers; outputs are derived from next-state values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            hold_q         <= '0;
            hold_valid_q   <= 1'b0;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            load_ready_q   <= 1'b0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            hold_valid_q   <= hold_valid_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            load_ready_q   <= ~hold_valid_d;
            serial_out_q   <= (state_d == ST_SHIFT) ? head_bit(shift_d) : 1'b0;
            serial_valid_q <= (state_d == ST_SHIFT);
            frame_start_q  <= (state_d == ST_SHIFT) && (bit_cnt_d == '0);
            done_q         <= done_d;
        end
    end

    assign load_ready_o   = load_ready_q;
    assign serial_out_o   = serial_out_q;
    assign serial_valid_o = serial_valid_q;
    assign frame_start_o  = frame_start_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three instances cover MSB-first
// WIDTH=8, LSB-first WIDTH=8 and LSB-first WIDTH=4.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       load_valid;
    logic       shift_en;
    logic [1:0] sel;

    logic [2:0] lr_s, so_s, sv_s, fs_s, dn_s;
    logic [2:0] lv_s;

    always #5 clk = ~clk;

    assign lv_s[0] = load_valid & (sel == 2'd0);
    assign lv_s[1] = load_valid & (sel == 2'd1);
    assign lv_s[2] = load_valid & (sel == 2'd2);

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk_i(clk), .rst_ni(rst_n), .data_in_i(data_in), .load_valid_i(lv_s[0]),
        .load_ready_o(lr_s[0]), .shift_en_i(shift_en), .serial_out_o(so_s[0]),
        .serial_valid_o(sv_s[0]), .frame_start_o(fs_s[0]), .done_o(dn_s[0]));

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
        .clk_i(clk), .rst_ni(rst_n), .data_in_i(data_in), .load_valid_i(lv_s[1]),
        .load_ready_o(lr_s[1]), .shift_en_i(shift_en), .serial_out_o(so_s[1]),
        .serial_valid_o(sv_s[1]), .frame_start_o(fs_s[1]), .done_o(dn_s[1]));

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb4 (
        .clk_i(clk), .rst_ni(rst_n), .data_in_i(data_in[3:0]), .load_valid_i(lv_s[2]),
        .load_ready_o(lr_s[2]), .shift_en_i(shift_en), .serial_out_o(so_s[2]),
        .serial_valid_o(sv_s[2]), .frame_start_o(fs_s[2]), .done_o(dn_s[2]));

    // Scoreboard entry: {first_bit, last_bit, bit_value}
    logic [2:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;
    bit         exp_done = 1'b0;
    int         done_cnt = 0;
    int         run = 0;
    int         max_run = 0;
    int         runs = 0;
    logic [7:0] sipo = 8'h00;

    task automatic push_word(input logic [7:0] w);
        int n;
        int idx;
        n = (sel == 2'd2) ? 4 : 8;
        for (int i = 0; i < n; i++) begin
            idx = (sel == 2'd0) ? (n - 1 - i) : i;
            exp_q.push_back({(i == 0), (i == n - 1), w[idx]});
        end
    endtask

    // One clock: monitor at the falling edge, then advance past the rising edge.
    task automatic cycle();
        logic [2:0] e;
        @(negedge clk);
        if (mon_en) begin
            checks++;
            if (dn_s[sel] !== exp_done) begin
                errors++;
                $display("FAIL done_pulse: got %b expected %b at %0t", dn_s[sel], exp_done, $time);
            end
            if (dn_s[sel] === 1'b1) done_cnt++;
            exp_done = 1'b0;
            if (sv_s[sel] !== 1'b1) begin
                run = 0;
                checks++;
                if ({so_s[sel], fs_s[sel]} !== 2'b00) begin
                    errors++;
                    $display("FAIL idle_outputs: got so=%b fs=%b expected 0 0 at %0t", so_s[sel], fs_s[sel], $time);
                end
            end else begin
                if (run == 0) runs++;
                run++;
                if (run > max_run) max_run = run;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit: got valid bit %b expected none at %0t", so_s[sel], $time);
                end else begin
                    e = exp_q[0];
                    if (so_s[sel] !== e[0] || fs_s[sel] !== e[2]) begin
                        errors++;
                        $display("FAIL serial_bit: got so=%b fs=%b expected so=%b fs=%b at %0t",
                                 so_s[sel], fs_s[sel], e[0], e[2], $time);
                    end
                    if (shift_en) begin
                        void'(exp_q.pop_front());
                        exp_done = e[1];
                        sipo = {sipo[6:0], so_s[sel]};
                    end
                end
            end
        end
        if (load_valid && lr_s[sel]) push_word(data_in);
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] w);
        bit acc;
        acc = 1'b0;
        data_in = w;
        load_valid = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            acc = lr_s[sel];
            cycle();
        end
        load_valid = 1'b0;
        data_in = 8'($urandom);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL load_timeout: got no accept expected accept of %h", w);
        end
    endtask

    task automatic drain(input int period);
        bit ok;
        int k;
        ok = 1'b0;
        k = 0;
        for (int c = 0; c < 200; c++) begin
            shift_en = ((k % period) == period - 1);
            k++;
            cycle();
            if (exp_q.size() == 0 && !exp_done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: got %0d bits pending expected 0", exp_q.size());
        end
        shift_en = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic clear_stats();
        done_cnt = 0;
        max_run = 0;
        runs = 0;
        run = 0;
        sipo = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_valid = 1'b0; shift_en = 1'b0; sel = 2'd0; data_in = 8'h00;
        #3;
        checks++;
        if ({lr_s, so_s, sv_s, fs_s, dn_s} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all 0", {lr_s, so_s, sv_s, fs_s, dn_s});
        end
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        checks++;
        if (lr_s !== 3'b111 || sv_s !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: got ready=%b valid=%b expected 111 000", lr_s, sv_s);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        sel = 2'd0; shift_en = 1'b1; clear_stats();
        load_word(8'hA5);
        checks++;
        if (sv_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got valid=%b expected 0", sv_s[0]);
        end
        cycle();
        checks++;
        if ({sv_s[0], so_s[0], fs_s[0]} !== 3'b111) begin
            errors++;
            $display("FAIL latency_first: got %b expected 111", {sv_s[0], so_s[0], fs_s[0]});
        end
        drain(1);
        checks++;
        if (sipo !== 8'hA5 || done_cnt != 1) begin
            errors++;
            $display("FAIL single_word: got sipo=%h done=%0d expected a5 1", sipo, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int lr_low;
        sel = 2'd0; shift_en = 1'b1; clear_stats();
        load_word(8'h3C);
        load_word(8'hC3);
        lr_low = 0;
        for (int c = 0; c < 40 && lr_s[0] !== 1'b1; c++) begin
            lr_low++;
            cycle();
        end
        checks++;
        if (lr_low != 7) begin
            errors++;
            $display("FAIL ready_low: got %0d cycles expected 7", lr_low);
        end
        drain(1);
        checks++;
        if (max_run != 16 || runs != 1 || done_cnt != 2) begin
            errors++;
            $display("FAIL back_to_back: got run=%0d runs=%0d done=%0d expected 16 1 2", max_run, runs, done_cnt);
        end
    endtask

    task automatic test_gap();
        sel = 2'd0; shift_en = 1'b1; clear_stats();
        load_word(8'hF0);
        for (int c = 0; c < 8; c++) cycle();
        load_word(8'h0F);
        drain(1);
        checks++;
        if (max_run != 8 || runs != 2 || done_cnt != 2) begin
            errors++;
            $display("FAIL late_load_gap: got run=%0d runs=%0d done=%0d expected 8 2 2", max_run, runs, done_cnt);
        end
    endtask

    task automatic test_stall();
        sel = 2'd0; shift_en = 1'b0; clear_stats();
        load_word(8'h81);
        drain(3);
        checks++;
        if (done_cnt != 1 || sipo !== 8'h81) begin
            errors++;
            $display("FAIL stall: got done=%0d sipo=%h expected 1 81", done_cnt, sipo);
        end
    endtask

    task automatic test_lsb_first();
        sel = 2'd1; shift_en = 1'b1; clear_stats();
        load_word(8'h01);
        drain(1);
        checks++;
        if (done_cnt != 1 || sipo !== 8'h80) begin
            errors++;
            $display("FAIL lsb8: got done=%0d bits=%h expected 1 80", done_cnt, sipo);
        end
        sel = 2'd2; clear_stats();
        load_word(8'h0B);
        drain(1);
        checks++;
        if (done_cnt != 1 || sipo[3:0] !== 4'hD) begin
            errors++;
            $display("FAIL lsb4: got done=%0d bits=%h expected 1 d", done_cnt, sipo[3:0]);
        end
    endtask

    task automatic test_reset_midword();
        sel = 2'd0; shift_en = 1'b1; clear_stats();
        load_word(8'hA5);
        for (int c = 0; c < 4; c++) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lr_s[0], so_s[0], sv_s[0], fs_s[0], dn_s[0]} !== 5'b00000) begin
            errors++;
            $display("FAIL midword_reset: got %b expected 00000", {lr_s[0], so_s[0], sv_s[0], fs_s[0], dn_s[0]});
        end
        exp_q.delete();
        exp_done = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        checks++;
        if (lr_s[0] !== 1'b1 || sv_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL midword_release: got ready=%b valid=%b expected 1 0", lr_s[0], sv_s[0]);
        end
        for (int c = 0; c < 12; c++) cycle();
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL abandoned_done: got %0d pulses expected 0", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_stall();
        test_lsb_first();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
